// File: rtl/stopwatch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : stopwatch_pkg
// Description : Shared state encodings, widths and lap record type for the
//               stopwatch control and datapath blocks.
// Revision    : 1.0 - initial release
// ============================================================================
package stopwatch_pkg;

    localparam int MIN_W = 8;
    localparam int SEC_W = 6;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'b00;
    localparam state_t ST_RUN   = 2'b01;
    localparam state_t ST_PAUSE = 2'b10;

    typedef struct packed {
        logic [MIN_W-1:0] minutes;
        logic [SEC_W-1:0] seconds;
    } lap_t;

endpackage
`default_nettype wire

// File: rtl/lap_fifo.sv
`default_nettype none
// ============================================================================
// Module      : lap_fifo
// Description : Show-ahead FIFO of lap records with flush, occupancy count
//               and a sticky overflow flag for pushes dropped while full.
// Revision    : 1.0 - initial release
// ============================================================================
module lap_fifo
    import stopwatch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_flush,
    input  logic                       i_push,
    input  lap_t                       i_data,
    input  logic                       i_ready,
    output logic                       o_valid,
    output lap_t                       o_data,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_overflow
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_CW = c_AW + 1;

    lap_t            r_mem [DEPTH];
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_CW-1:0] r_count;
    logic            r_overflow;

    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_push_ok;

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == c_CW'(DEPTH));
    assign w_pop     = !w_empty && i_ready;
    // A pop in the same cycle frees the slot the push needs.
    assign w_push_ok = i_push && (!w_full || w_pop);

    always_ff @(posedge clk) begin
        if (w_push_ok && !i_flush && !rst) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (i_push && !w_push_ok) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign o_valid    = !w_empty;
    assign o_data     = w_empty ? lap_t'('0) : r_mem[r_rd_ptr];
    assign o_count    = r_count;
    assign o_overflow = r_overflow;

endmodule
`default_nettype wire

// File: rtl/stopwatch_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : stopwatch_sequencer
// Description : Run/pause FSM, count-tick prescaler and lap capture FIFO
//               driving the stopwatch minutes:seconds counter datapath.
// Revision    : 1.0 - initial release
// ============================================================================
module stopwatch_sequencer
    import stopwatch_pkg::*;
#(
    parameter int TICK_DIV  = 1,
    parameter int LAP_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         stop,
    input  logic                         reset,
    input  logic                         lap,
    input  logic [MIN_W-1:0]             cur_minutes,
    input  logic [SEC_W-1:0]             cur_seconds,
    output logic                         tick_en,
    output logic                         clear_cnt,
    output logic [1:0]                   status,
    output logic                         lap_valid,
    input  logic                         lap_ready,
    output logic [MIN_W-1:0]             lap_minutes,
    output logic [SEC_W-1:0]             lap_seconds,
    output logic [$clog2(LAP_DEPTH):0]   lap_count,
    output logic                         lap_overflow
);

    localparam int c_PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [c_PW-1:0] c_PRESC_MAX = c_PW'(TICK_DIV - 1);

    state_t          r_state;
    state_t          w_state_next;
    logic [c_PW-1:0] r_presc;
    logic            r_clear_cnt;
    logic            w_push;
    lap_t            w_lap_in;
    lap_t            w_lap_head;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; stop outranks start, which only matters in RUN
    always_comb begin
        w_state_next = r_state;
        if (reset) begin
            w_state_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:  if (start) w_state_next = ST_RUN;
                ST_RUN:   if (stop)  w_state_next = ST_PAUSE;
                ST_PAUSE: if (start) w_state_next = ST_RUN;
                default:  w_state_next = ST_IDLE;
            endcase
        end
    end

    // Prescaler holds in PAUSE so a partial tick survives pause/resume.
    always_ff @(posedge clk) begin
        if (rst || reset) begin
            r_presc <= '0;
        end else begin
            case (r_state)
                ST_RUN:   r_presc <= (r_presc == c_PRESC_MAX) ? '0 : r_presc + 1'b1;
                ST_PAUSE: r_presc <= r_presc;
                default:  r_presc <= '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_clear_cnt <= 1'b0;
        end else begin
            r_clear_cnt <= reset;
        end
    end

    // Output logic
    always_comb begin
        status    = r_state;
        tick_en   = (r_state == ST_RUN) && (r_presc == c_PRESC_MAX);
        clear_cnt = r_clear_cnt;
    end

    assign w_push   = lap && !reset && ((r_state == ST_RUN) || (r_state == ST_PAUSE));
    assign w_lap_in = '{minutes: cur_minutes, seconds: cur_seconds};

    lap_fifo #(
        .DEPTH (LAP_DEPTH)
    ) u_lap_fifo (
        .clk        (clk),
        .rst        (rst),
        .i_flush    (reset),
        .i_push     (w_push),
        .i_data     (w_lap_in),
        .i_ready    (lap_ready),
        .o_valid    (lap_valid),
        .o_data     (w_lap_head),
        .o_count    (lap_count),
        .o_overflow (lap_overflow)
    );

    assign lap_minutes = w_lap_head.minutes;
    assign lap_seconds = w_lap_head.seconds;

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_stopwatch_sequencer
// Description : Directed self-checking bench; one instance at TICK_DIV=1 and
//               one at TICK_DIV=3 share the same command stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stopwatch_sequencer;

    logic       clk = 1'b0;
    logic       rst, start, stop, reset, lap, lap_ready;
    logic [7:0] cur_minutes;
    logic [5:0] cur_seconds;

    logic       d1_tick, d1_clr, d1_valid, d1_ovf;
    logic [1:0] d1_status;
    logic [7:0] d1_min;
    logic [5:0] d1_sec;
    logic [2:0] d1_cnt;

    logic       d3_tick, d3_clr, d3_valid, d3_ovf;
    logic [1:0] d3_status;
    logic [7:0] d3_min;
    logic [5:0] d3_sec;
    logic [2:0] d3_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    stopwatch_sequencer #(.TICK_DIV(1), .LAP_DEPTH(4)) u_dut1 (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .reset(reset), .lap(lap),
        .cur_minutes(cur_minutes), .cur_seconds(cur_seconds),
        .tick_en(d1_tick), .clear_cnt(d1_clr), .status(d1_status),
        .lap_valid(d1_valid), .lap_ready(lap_ready),
        .lap_minutes(d1_min), .lap_seconds(d1_sec),
        .lap_count(d1_cnt), .lap_overflow(d1_ovf)
    );

    stopwatch_sequencer #(.TICK_DIV(3), .LAP_DEPTH(4)) u_dut3 (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .reset(reset), .lap(lap),
        .cur_minutes(cur_minutes), .cur_seconds(cur_seconds),
        .tick_en(d3_tick), .clear_cnt(d3_clr), .status(d3_status),
        .lap_valid(d3_valid), .lap_ready(lap_ready),
        .lap_minutes(d3_min), .lap_seconds(d3_sec),
        .lap_count(d3_cnt), .lap_overflow(d3_ovf)
    );

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Advance one edge; outputs are then observed 1ns after it.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; reset = 1'b0; lap = 1'b0;
        lap_ready = 1'b0; cur_minutes = '0; cur_seconds = '0;
        cycle();
        cycle();
        check_eq("rst_status", int'(d1_status), 0);
        check_eq("rst_tick",   int'(d1_tick),   0);
        check_eq("rst_clr",    int'(d1_clr),    0);
        check_eq("rst_valid",  int'(d1_valid),  0);
        check_eq("rst_count",  int'(d1_cnt),    0);
        check_eq("rst_ovf",    int'(d1_ovf),    0);
        check_eq("rst_min",    int'(d1_min),    0);
        rst = 1'b0;
        cycle();

        // TICK_DIV=1 run / pause / resume
        start = 1'b1; cycle(); start = 1'b0;
        check_eq("t1_status_run", int'(d1_status), 1);
        for (int i = 0; i < 5; i++) begin
            check_eq($sformatf("t1_tick%0d", i), int'(d1_tick), 1);
            cycle();
        end
        stop = 1'b1; cycle(); stop = 1'b0;
        check_eq("t1_status_pause", int'(d1_status), 2);
        check_eq("t1_tick_pause",   int'(d1_tick),   0);
        start = 1'b1; cycle(); start = 1'b0;
        check_eq("t1_status_resume", int'(d1_status), 1);
        check_eq("t1_tick_resume",   int'(d1_tick),   1);

        // start+stop+reset together while RUNNING
        start = 1'b1; stop = 1'b1; reset = 1'b1; cycle();
        start = 1'b0; stop = 1'b0; reset = 1'b0;
        check_eq("ssr_status", int'(d1_status), 0);
        check_eq("ssr_clr",    int'(d1_clr),    1);
        check_eq("ssr_tick",   int'(d1_tick),   0);
        cycle();
        check_eq("ssr_clr_low", int'(d1_clr), 0);

        // TICK_DIV=3: 7 running cycles, pause 10, resume to running cycle 10
        start = 1'b1; cycle(); start = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            check_eq($sformatf("t3_tick_run%0d", k), int'(d3_tick), (k % 3 == 0) ? 1 : 0);
            if (k == 7) stop = 1'b1;
            cycle();
        end
        stop = 1'b0;
        check_eq("t3_status_pause", int'(d3_status), 2);
        for (int j = 0; j < 10; j++) begin
            check_eq($sformatf("t3_tick_pause%0d", j), int'(d3_tick), 0);
            cycle();
        end
        start = 1'b1; cycle(); start = 1'b0;
        for (int k = 8; k <= 10; k++) begin
            check_eq($sformatf("t3_tick_run%0d", k), int'(d3_tick), (k % 3 == 0) ? 1 : 0);
            cycle();
        end
        reset = 1'b1; cycle(); reset = 1'b0;
        check_eq("t3_status_idle", int'(d3_status), 0);
        check_eq("t3_tick_idle",   int'(d3_tick),   0);

        // start+stop in IDLE resolves to RUNNING
        start = 1'b1; stop = 1'b1; cycle(); start = 1'b0; stop = 1'b0;
        check_eq("idle_ss_status", int'(d1_status), 1);

        // lap capture, then lap with stop
        cur_minutes = 8'd2; cur_seconds = 6'd15; lap = 1'b1; cycle();
        cur_minutes = 8'd2; cur_seconds = 6'd20; stop = 1'b1; cycle();
        lap = 1'b0; stop = 1'b0;
        check_eq("lap_count2",   int'(d1_cnt),    2);
        check_eq("lap_head_min", int'(d1_min),    2);
        check_eq("lap_head_sec", int'(d1_sec),    15);
        check_eq("lap_status",   int'(d1_status), 2);
        check_eq("lap_valid",    int'(d1_valid),  1);
        reset = 1'b1; cycle(); reset = 1'b0;
        check_eq("flush_count", int'(d1_cnt), 0);
        lap = 1'b1; cycle(); lap = 1'b0;
        check_eq("idle_lap_count", int'(d1_cnt), 0);

        // overflow: 5 pushes into a 4-deep FIFO
        start = 1'b1; cycle(); start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cur_minutes = 8'(10 + i); cur_seconds = 6'(i); lap = 1'b1;
            cycle();
        end
        lap = 1'b0;
        check_eq("ovf_count",    int'(d1_cnt), 4);
        check_eq("ovf_flag",     int'(d1_ovf), 1);
        check_eq("ovf_head_min", int'(d1_min), 10);
        cur_minutes = 8'd20; cur_seconds = 6'd30; lap = 1'b1; lap_ready = 1'b1;
        cycle();
        lap = 1'b0; lap_ready = 1'b0;
        check_eq("pp_count",    int'(d1_cnt), 4);
        check_eq("pp_head_min", int'(d1_min), 11);
        check_eq("pp_head_sec", int'(d1_sec), 1);
        lap_ready = 1'b1;
        check_eq("drain0_min", int'(d1_min), 11); cycle();
        check_eq("drain1_min", int'(d1_min), 12); cycle();
        check_eq("drain2_min", int'(d1_min), 13); cycle();
        check_eq("drain3_min", int'(d1_min), 20);
        check_eq("drain3_sec", int'(d1_sec), 30); cycle();
        check_eq("empty_valid", int'(d1_valid), 0);
        check_eq("empty_min",   int'(d1_min),   0);
        check_eq("empty_sec",   int'(d1_sec),   0);
        cycle();
        lap_ready = 1'b0;
        check_eq("empty_pop_count", int'(d1_cnt), 0);
        check_eq("ovf_sticky",      int'(d1_ovf), 1);

        // rst mid-run with 3 laps queued
        for (int i = 0; i < 3; i++) begin
            cur_minutes = 8'(30 + i); cur_seconds = 6'(i); lap = 1'b1;
            cycle();
        end
        lap = 1'b0;
        check_eq("pre_rst_count", int'(d1_cnt), 3);
        rst = 1'b1; cycle(); rst = 1'b0;
        check_eq("mid_rst_status", int'(d1_status), 0);
        check_eq("mid_rst_count",  int'(d1_cnt),    0);
        check_eq("mid_rst_ovf",    int'(d1_ovf),    0);
        check_eq("mid_rst_tick",   int'(d1_tick),   0);
        check_eq("mid_rst_clr",    int'(d1_clr),    0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/stopwatch_sequencer.md
Name: stopwatch_sequencer

Overview:
Control block for the stopwatch counter datapath. It turns the start/stop/reset/lap command pulses into a 3-state run/pause FSM and a prescaled count-enable tick for the minutes:seconds counter. It also captures lap times into a small show-ahead FIFO that a display or UART reader drains with a valid/ready handshake. It sits between the button/command front end and the counter datapath inside the stopwatch top level.

Parameters:
TICK_DIV, 1, clk cycles per count tick (>=1); 1 = tick every cycle while running.
LAP_DEPTH, 4, lap FIFO entries (power of two, >=2).

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous active-high reset
start  input  1  start/resume command, 1-cycle pulse
stop  input  1  pause command, 1-cycle pulse
reset  input  1  clear command (user-level), 1-cycle pulse
lap  input  1  lap capture command, 1-cycle pulse
cur_minutes  input  8  current datapath minutes
cur_seconds  input  6  current datapath seconds
tick_en  output  1  datapath count enable, 1 cycle per tick
clear_cnt  output  1  datapath clear pulse
status  output  2  00 IDLE, 01 RUNNING, 10 PAUSED
lap_valid  output  1  FIFO head holds a lap
lap_ready  input  1  reader accepts head this cycle
lap_minutes  output  8  head lap minutes (0 when empty)
lap_seconds  output  6  head lap seconds (0 when empty)
lap_count  output  clog2(LAP_DEPTH)+1  entries held
lap_overflow  output  1  sticky: a lap was dropped because the FIFO was full

Behaviour:
- rst (sync, active-high): state IDLE, prescaler 0, FIFO empty, lap_overflow 0. All outputs 0, clear_cnt included. rst overrides every input, including mid-run.
- Command priority per cycle: reset > stop > start. lap is evaluated independently but is suppressed by reset.
- FSM (registered, status = state encoding):
  - IDLE: start -> RUNNING; stop ignored.
  - RUNNING: stop -> PAUSED; start ignored.
  - PAUSED: start -> RUNNING; stop ignored.
  - Encoding 11 is unreachable; if it occurs, go to IDLE.
- reset command, any state: next state IDLE, prescaler 0, FIFO flushed, lap_overflow cleared.
  - clear_cnt is registered: high for exactly the cycle after the reset sample.
- Prescaler:
  - Counts 0..TICK_DIV-1 only in RUNNING and wraps to 0.
  - Holds its value in PAUSED, so a partial tick is preserved across pause/resume.
  - Cleared in IDLE.
- tick_en = (state==RUNNING) && (prescaler==TICK_DIV-1), decoded from registers. It is never high in IDLE or PAUSED.
  - TICK_DIV=1: tick_en is high every RUNNING cycle. The first tick is the cycle after the edge that sampled start.
  - Stop sampled at edge N: tick_en is low from cycle N+1.
- Lap capture:
  - Accepted when lap=1, reset=0, and state (pre-transition) is RUNNING or PAUSED. It is ignored in IDLE.
  - Captures cur_minutes/cur_seconds as sampled on that edge; if tick_en is also high, the pre-increment value is stored.
  - lap with stop in the same cycle: the lap is captured and the state goes to PAUSED.
- Lap FIFO (show-ahead):
  - lap_valid = (lap_count!=0). The head is presented combinationally from storage; data outputs are forced to 0 when empty.
  - Pop when lap_valid && lap_ready. lap_ready while empty has no effect.
  - Push while full without a pop: the entry is dropped and lap_overflow is set (sticky until rst/reset).
  - Push and pop in the same cycle while full: both happen and lap_count is unchanged.
  - Push and pop while empty: push only, since the pop is not valid.
  - Pointers wrap modulo LAP_DEPTH; lap_count saturates at LAP_DEPTH.

Decomposition:
- Shared package stopwatch_pkg:
  - state typedef / localparams ST_IDLE=2'b00, ST_RUN=2'b01, ST_PAUSE=2'b10 (also used by the datapath and benches).
  - Widths MIN_W=8, SEC_W=6.
- One sub-module, lap_fifo: parameterised-depth show-ahead FIFO holding {minutes,seconds}, with flush, count and overflow flag.
- FSM and prescaler stay in stopwatch_sequencer.

Test Plan:
- TICK_DIV=1: rst 2 cycles, start pulse -> status 01 next cycle, tick_en high for 5 consecutive cycles. Stop pulse -> status 10, tick_en 0 the cycle after; start again -> status 01, ticks resume.
- TICK_DIV=3: start, run 7 cycles, stop, wait 10 cycles, start -> ticks at running-cycle counts 3, 6, then 9 (prescaler phase held across the pause); no tick while PAUSED.
- Simultaneous start+stop+reset while RUNNING -> status 00, clear_cnt high exactly 1 cycle, tick_en 0. start+stop in IDLE -> status 01.
- Drive cur=02:15 and pulse lap in RUNNING, then cur=02:20 with lap+stop -> lap_count 2, head 02:15, status 10. Pulse lap in IDLE -> no push.
- Push 5 laps with lap_ready=0 (LAP_DEPTH=4) -> lap_count 4, lap_overflow 1, 5th dropped. Then push+pop in the same cycle -> count stays 4, head advances. Drain -> lap_valid 0, data 0.
- Assert rst mid-RUN with 3 laps queued -> next cycle status 00, lap_count 0, lap_overflow 0, tick_en 0, clear_cnt 0.
